// File: rtl/run_sequencer_pkg.sv
// rtl/run_sequencer_pkg.sv - shared run-control op codes, state encodings and status word layout
package run_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_NOOP  = 2'b00,
        OP_START = 2'b01,
        OP_STOP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ARMING   = 2'b01,
        RUNNING  = 2'b10,
        STOPPING = 2'b11
    } state_t;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 14;
    localparam int VAL_WIDTH = 14;

    localparam int STAT_STATE_MSB = 15;
    localparam int STAT_STATE_LSB = 14;
    localparam int STAT_PENDING   = 13;
    localparam int STAT_ERR       = 12;
    localparam int STAT_FRAME_MSB = 11;

    function automatic logic [15:0] pack_status(input state_t st, input logic pend,
                                                input logic err, input logic [11:0] frames);
        return {st, pend, err, frames};
    endfunction

endpackage

// File: rtl/run_sequencer_cmd_decoder.sv
// rtl/run_sequencer_cmd_decoder.sv - splits host command words and classifies them against the run state
module run_sequencer_cmd_decoder
    import run_sequencer_pkg::*;
#(
    parameter int MIN_INTG_VAL = 16
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    input  logic [15:0]          cmd_word,
    input  state_t               state,
    output logic                 cmd_ready,
    output logic [VAL_WIDTH-1:0] val,
    output logic                 legal_start,
    output logic                 legal_stop,
    output logic                 rejected,
    output logic                 cmd_error
);

    op_t  op;
    logic accept;
    logic val_ok;
    logic bad_cmd;

    always_comb begin
        op        = op_t'(cmd_word[OP_MSB:OP_LSB]);
        val       = cmd_word[VAL_WIDTH-1:0];
        cmd_ready = (state != ARMING);
        accept    = cmd_valid && cmd_ready;
        val_ok    = (val >= VAL_WIDTH'(MIN_INTG_VAL));
        // A START while STOPPING is refused: the previous run has not finished its last frame.
        case (op)
            OP_RSVD:  bad_cmd = 1'b1;
            OP_START: bad_cmd = (state == STOPPING) || !val_ok;
            default:  bad_cmd = 1'b0;
        endcase
        legal_start = accept && (op == OP_START) && !bad_cmd;
        legal_stop  = accept && (op == OP_STOP);
        rejected    = accept && bad_cmd;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            cmd_error <= 1'b0;
        end else begin
            cmd_error <= rejected;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - run-control FSM: arming, integration count, frame counting and status reporting
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int MIN_INTG_VAL       = 16,
    parameter int ARM_CYCLES         = 8,
    parameter int DEFAULT_INTG_COUNT = 5000
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_word,
    output logic        cmd_ready,
    input  logic        frame_done,
    output logic        running,
    output logic        afe_reset,
    output logic [31:0] integration_clock_count,
    output logic [31:0] frame_count,
    output logic        cmd_error,
    output logic [15:0] status_word
);

    localparam int ARM_W = $clog2(ARM_CYCLES + 1);

    state_t               state, state_nxt;
    logic [VAL_WIDTH-1:0] val;
    logic                 legal_start, legal_stop, rejected;
    logic [ARM_W-1:0]     arm_cnt;
    logic                 arm_last;
    logic [15:0]          pending_count;
    logic                 pending_valid;
    logic                 err_sticky;
    logic                 start_run, arm_done, frame_tick, end_run, queue_pending;

    run_sequencer_cmd_decoder #(
        .MIN_INTG_VAL(MIN_INTG_VAL)
    ) u_decoder (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_word   (cmd_word),
        .state      (state),
        .cmd_ready  (cmd_ready),
        .val        (val),
        .legal_start(legal_start),
        .legal_stop (legal_stop),
        .rejected   (rejected),
        .cmd_error  (cmd_error)
    );

    assign arm_last = (arm_cnt == ARM_W'(ARM_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (legal_start) state_nxt = ARMING;
            ARMING:   if (arm_last)    state_nxt = RUNNING;
            RUNNING:  if (legal_stop)  state_nxt = STOPPING;
            STOPPING: if (frame_done)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_run     = (state == IDLE) && legal_start;
        arm_done      = (state == ARMING) && arm_last;
        frame_tick    = frame_done && ((state == RUNNING) || (state == STOPPING));
        end_run       = frame_done && (state == STOPPING);
        queue_pending = (state == RUNNING) && legal_start;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            running                 <= 1'b0;
            afe_reset               <= 1'b0;
            integration_clock_count <= 32'(DEFAULT_INTG_COUNT);
            frame_count             <= 32'd0;
            pending_count           <= 16'd0;
            pending_valid           <= 1'b0;
            err_sticky              <= 1'b0;
            arm_cnt                 <= '0;
            status_word             <= 16'd0;
        end else begin
            status_word <= pack_status(state, pending_valid, err_sticky, frame_count[STAT_FRAME_MSB:0]);

            if (rejected) begin
                err_sticky <= 1'b1;
            end else if (start_run) begin
                err_sticky <= 1'b0;
            end

            if (start_run) begin
                arm_cnt                 <= '0;
                integration_clock_count <= {16'b0, val, 2'b00};
                frame_count             <= 32'd0;
                afe_reset               <= 1'b1;
            end else if (state == ARMING) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end

            if (arm_done) begin
                afe_reset <= 1'b0;
                running   <= 1'b1;
            end

            // Older pending is applied at the frame boundary before a same-cycle START can replace it.
            if (frame_tick) begin
                if (frame_count != 32'hFFFF_FFFF) begin
                    frame_count <= frame_count + 32'd1;
                end
                if ((state == RUNNING) && pending_valid) begin
                    integration_clock_count <= {16'b0, pending_count};
                    pending_valid           <= 1'b0;
                end
            end

            if (end_run) begin
                running       <= 1'b0;
                pending_valid <= 1'b0;
            end

            if (queue_pending) begin
                pending_count <= {val, 2'b00};
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - directed self-checking bench for run_sequencer
module tb_run_sequencer;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_word = 16'd0;
    logic        cmd_ready;
    logic        frame_done = 1'b0;
    logic        running;
    logic        afe_reset;
    logic [31:0] integration_clock_count;
    logic [31:0] frame_count;
    logic        cmd_error;
    logic [15:0] status_word;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] START_100 = 16'h4064;
    localparam logic [15:0] START_10  = 16'h400A;
    localparam logic [15:0] START_200 = 16'h40C8;
    localparam logic [15:0] STOP_CMD  = 16'h8000;
    localparam logic [15:0] RSVD_CMD  = 16'hC000;

    run_sequencer dut (
        .clk_in                 (clk_in),
        .reset_n                (reset_n),
        .cmd_valid              (cmd_valid),
        .cmd_word               (cmd_word),
        .cmd_ready              (cmd_ready),
        .frame_done             (frame_done),
        .running                (running),
        .afe_reset              (afe_reset),
        .integration_clock_count(integration_clock_count),
        .frame_count            (frame_count),
        .cmd_error              (cmd_error),
        .status_word            (status_word)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        cmd_valid = 1'b1;
        cmd_word  = w;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic run_to_running(input logic [15:0] w);
        do_reset();
        send(w);
        for (int i = 0; i < 20 && running !== 1'b1; i++) tick();
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL run_up_timeout running=%0b required=1", running);
        end
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%0b exp=0", running); end
        total++; if (afe_reset !== 1'b0) begin bad++; $display("FAIL reset_afe got=%0b exp=0", afe_reset); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
        total++; if (integration_clock_count !== 32'd5000) begin bad++; $display("FAIL reset_count got=%0d exp=5000", integration_clock_count); end
        total++; if (frame_count !== 32'd0) begin bad++; $display("FAIL reset_frames got=%0d exp=0", frame_count); end
        total++; if (status_word !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h exp=0000", status_word); end
    endtask

    task automatic test_start_legal;
        do_reset();
        send(START_100);
        total++; if (cmd_error !== 1'b0) begin bad++; $display("FAIL start_err got=%0b exp=0", cmd_error); end
        total++; if (integration_clock_count !== 32'd400) begin bad++; $display("FAIL start_count got=%0d exp=400", integration_clock_count); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (afe_reset !== 1'b1 || running !== 1'b0) begin
                bad++;
                $display("FAIL arm_cycle%0d afe=%0b run=%0b exp afe=1 run=0", i, afe_reset, running);
            end
            if (i < 7) tick();
        end
        tick();
        total++; if (afe_reset !== 1'b0) begin bad++; $display("FAIL arm_end_afe got=%0b exp=0", afe_reset); end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL arm_end_run got=%0b exp=1", running); end
        tick();
        total++; if (status_word[15:14] !== 2'b10) begin bad++; $display("FAIL start_state got=%b exp=10", status_word[15:14]); end
    endtask

    task automatic test_start_illegal;
        do_reset();
        send(START_10);
        total++; if (cmd_error !== 1'b1) begin bad++; $display("FAIL illegal_err got=%0b exp=1", cmd_error); end
        total++; if (integration_clock_count !== 32'd5000) begin bad++; $display("FAIL illegal_count got=%0d exp=5000", integration_clock_count); end
        tick();
        total++; if (cmd_error !== 1'b0) begin bad++; $display("FAIL illegal_pulse got=%0b exp=0", cmd_error); end
        total++; if (status_word !== 16'h1000) begin bad++; $display("FAIL illegal_status got=%h exp=1000", status_word); end
    endtask

    task automatic test_pending;
        run_to_running(START_100);
        send(START_200);
        total++; if (integration_clock_count !== 32'd400) begin bad++; $display("FAIL pend_hold got=%0d exp=400", integration_clock_count); end
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        total++; if (integration_clock_count !== 32'd800) begin bad++; $display("FAIL pend_apply got=%0d exp=800", integration_clock_count); end
        tick();
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        total++; if (frame_count !== 32'd2) begin bad++; $display("FAIL pend_frames got=%0d exp=2", frame_count); end
        tick();
        total++; if (status_word !== 16'h8002) begin bad++; $display("FAIL pend_status got=%h exp=8002", status_word); end
    endtask

    task automatic test_stop_frame;
        run_to_running(START_100);
        cmd_valid = 1'b1; cmd_word = STOP_CMD; frame_done = 1'b1;
        tick();
        cmd_valid = 1'b0; frame_done = 1'b0;
        total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL stop_frames got=%0d exp=1", frame_count); end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL stop_running got=%0b exp=1", running); end
        tick();
        total++; if (status_word !== 16'hC001) begin bad++; $display("FAIL stop_status got=%h exp=c001", status_word); end
        send(START_100);
        total++; if (cmd_error !== 1'b1) begin bad++; $display("FAIL stopping_start_err got=%0b exp=1", cmd_error); end
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        total++; if (running !== 1'b0) begin bad++; $display("FAIL stop_end_run got=%0b exp=0", running); end
        total++; if (frame_count !== 32'd2) begin bad++; $display("FAIL stop_end_frames got=%0d exp=2", frame_count); end
        tick();
        total++; if (status_word !== 16'h1002) begin bad++; $display("FAIL stop_end_status got=%h exp=1002", status_word); end
    endtask

    task automatic test_reserved;
        run_to_running(START_100);
        send(RSVD_CMD);
        total++; if (cmd_error !== 1'b1) begin bad++; $display("FAIL rsvd_err got=%0b exp=1", cmd_error); end
        total++; if (running !== 1'b1 || integration_clock_count !== 32'd400) begin
            bad++; $display("FAIL rsvd_run run=%0b count=%0d exp run=1 count=400", running, integration_clock_count);
        end
        tick();
        total++; if (cmd_error !== 1'b0) begin bad++; $display("FAIL rsvd_pulse got=%0b exp=0", cmd_error); end
        total++; if (status_word !== 16'h9000) begin bad++; $display("FAIL rsvd_status got=%h exp=9000", status_word); end
    endtask

    task automatic test_held_arming;
        do_reset();
        cmd_valid = 1'b1; cmd_word = START_100;
        tick();
        cmd_word = STOP_CMD;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cmd_ready !== 1'b0) begin bad++; $display("FAIL held_ready%0d got=%0b exp=0", i, cmd_ready); end
            tick();
        end
        total++; if (cmd_ready !== 1'b1 || running !== 1'b1) begin
            bad++; $display("FAIL held_release ready=%0b run=%0b exp 1 1", cmd_ready, running);
        end
        tick();
        cmd_valid = 1'b0;
        tick();
        total++; if (status_word[15:14] !== 2'b11 || running !== 1'b1) begin
            bad++; $display("FAIL held_stop state=%b run=%0b exp state=11 run=1", status_word[15:14], running);
        end
    endtask

    task automatic test_reset_stopping;
        run_to_running(START_100);
        cmd_valid = 1'b1; cmd_word = STOP_CMD; frame_done = 1'b1;
        tick();
        cmd_valid = 1'b0; frame_done = 1'b0;
        tick();
        do_reset();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_mid_run got=%0b exp=0", running); end
        total++; if (frame_count !== 32'd0) begin bad++; $display("FAIL rst_mid_frames got=%0d exp=0", frame_count); end
        total++; if (integration_clock_count !== 32'd5000) begin bad++; $display("FAIL rst_mid_count got=%0d exp=5000", integration_clock_count); end
        total++; if (status_word !== 16'h0000) begin bad++; $display("FAIL rst_mid_status got=%h exp=0000", status_word); end
    endtask

    initial begin
        test_reset();
        test_start_legal();
        test_start_illegal();
        test_pending();
        test_stop_frame();
        test_reserved();
        test_held_arming();
        test_reset_stopping();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
